tx_ipv4: RTL and testbench

TX_IPV4 -- requirements
Module: tx_ipv4

---
 rtl/vthernet_pkg.sv | 55 +++++
 rtl/ipv4_csum.sv | 38 +++
 rtl/tx_ipv4.sv | 149 ++++++++++++++
 tb/tb_tx_ipv4.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vthernet_pkg.sv
// Shared IPv4 transmit types, header constants and header word helper.
// Used by tx_ipv4 and ipv4_csum.
package vthernet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_FOLD,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [3:0]  IPV4_VERSION     = 4'd4;
  localparam logic [3:0]  IPV4_IHL         = 4'd5;
  localparam logic [15:0] IPV4_HDR_BYTES   = 16'd20;
  localparam logic [15:0] IPV4_MAX_PAYLOAD = 16'd1480;
  localparam logic [15:0] IPV4_FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  IPV4_PROTO_UDP   = 8'h11;
  localparam logic [15:0] CSUM_WORDS       = 16'd10;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  tos;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] id;
    logic [15:0] len;
  } hdr_t;

  function automatic logic [15:0] hdr_word(
    input hdr_t        h,
    input logic [3:0]  idx,
    input logic [15:0] csum
  );
    logic [15:0] w;
    w = '0;
    case (idx)
      4'd0: w = {IPV4_VERSION, IPV4_IHL, h.tos};
      4'd1: w = IPV4_HDR_BYTES + h.len;
      4'd2: w = h.id;
      4'd3: w = IPV4_FLAGS_DF;
      4'd4: w = {h.ttl, h.proto};
      4'd5: w = csum;
      4'd6: w = h.src[31:16];
      4'd7: w = h.src[15:0];
      4'd8: w = h.dst[31:16];
      4'd9: w = h.dst[15:0];
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Ones-complement header checksum: clear, accumulate words, fold.
// Carries are wrapped on every add so 17 bits never overflow.
module ipv4_csum
  import vthernet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [16:0] acc;
  logic [16:0] t;
  logic [15:0] f;

  always_comb begin
    t = {1'b0, acc[15:0]} + {16'd0, acc[16]};
    f = t[15:0] + {15'd0, t[16]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sum <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]}
             + {1'b0, word};
    end else if (fold) begin
      sum <= ~f;
    end
  end

endmodule

// File: rtl/tx_ipv4.sv
// IPv4 datagram transmitter: header build, checksum, payload pass-through.
// Define TX_IPV4_CHECKSUM_EN to compute the header checksum (else 0).
module tx_ipv4
  import vthernet_pkg::*;
#(
  parameter int             OCT = 8,
  parameter logic [OCT-1:0] UDP = 8'h11
) (
  input  logic             TX_CLK,
  input  logic             rst,
  input  logic             func_en,
  input  logic [OCT*4-1:0] ip_addr,
  input  logic [OCT*4-1:0] tx_dst_ip,
  input  logic [OCT-1:0]   tx_tos,
  input  logic [OCT-1:0]   tx_ttl,
  input  logic [OCT-1:0]   tx_protocol,
  input  logic [OCT*2-1:0] tx_id,
  input  logic [OCT*2-1:0] tx_payload_len,
  input  logic             tx_ipv4_start,
  output logic             tx_ipv4_busy,
  input  logic             tx_payload_v,
  input  logic [OCT-1:0]   tx_payload_data,
  output logic             tx_payload_ready,
  output logic             tx_ipv4_data_v,
  output logic [OCT-1:0]   tx_ipv4_data,
  output logic             tx_ipv4_irq,
  output logic             tx_ipv4_err
);

  state_t      state;
  hdr_t        hdr;
  logic [15:0] cnt;
  logic [15:0] csum;
  logic [15:0] out_word;
  logic [7:0]  hdr_byte;

  assign out_word = hdr_word(hdr, cnt[4:1], csum);
  assign hdr_byte = cnt[0] ? out_word[7:0] : out_word[15:8];

`ifdef TX_IPV4_CHECKSUM_EN
  logic [15:0] sum_word;
  logic        cs_clr;
  logic        cs_add;
  logic        cs_fold;

  // Checksum field reads as zero while it is being summed
  assign sum_word = hdr_word(hdr, cnt[3:0], 16'h0000);
  assign cs_clr   = func_en && (state == S_IDLE);
  assign cs_add   = func_en && (state == S_CSUM);
  assign cs_fold  = func_en && (state == S_FOLD);

  ipv4_csum u_csum (
    .clk  (TX_CLK),
    .rst  (rst),
    .clr  (cs_clr),
    .add  (cs_add),
    .fold (cs_fold),
    .word (sum_word),
    .sum  (csum)
  );
`else
  assign csum = 16'h0000;
`endif

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state            <= S_IDLE;
      hdr              <= '{proto: UDP, default: '0};
      cnt              <= '0;
      tx_ipv4_busy     <= 1'b0;
      tx_payload_ready <= 1'b0;
      tx_ipv4_data_v   <= 1'b0;
      tx_ipv4_data     <= '0;
      tx_ipv4_irq      <= 1'b0;
      tx_ipv4_err      <= 1'b0;
    end else if (func_en) begin
      tx_ipv4_irq <= 1'b0;
      tx_ipv4_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx_ipv4_start) begin
            if (tx_payload_len == '0 ||
                tx_payload_len > IPV4_MAX_PAYLOAD) begin
              tx_ipv4_err <= 1'b1;
            end else begin
              hdr <= '{src:   ip_addr,
                       dst:   tx_dst_ip,
                       tos:   tx_tos,
                       ttl:   tx_ttl,
                       proto: tx_protocol,
                       id:    tx_id,
                       len:   tx_payload_len};
              cnt          <= '0;
              tx_ipv4_busy <= 1'b1;
              state        <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          cnt <= cnt + 16'd1;
          if (cnt == CSUM_WORDS - 16'd1) begin
            cnt   <= '0;
            state <= S_FOLD;
          end
        end
        S_FOLD: begin
          tx_ipv4_data   <= hdr_byte;
          tx_ipv4_data_v <= 1'b1;
          cnt            <= 16'd1;
          state          <= S_HDR;
        end
        S_HDR: begin
          tx_ipv4_data <= hdr_byte;
          cnt          <= cnt + 16'd1;
          // Ready rises with the last header byte so payload follows gaplessly
          if (cnt == IPV4_HDR_BYTES - 16'd1) begin
            cnt              <= '0;
            tx_payload_ready <= 1'b1;
            state            <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_payload_v) begin
            tx_ipv4_data <= tx_payload_data;
            cnt          <= cnt + 16'd1;
            if (cnt == hdr.len - 16'd1) begin
              tx_payload_ready <= 1'b0;
              state            <= S_DONE;
            end
          end else begin
            tx_ipv4_data_v   <= 1'b0;
            tx_payload_ready <= 1'b0;
            tx_ipv4_busy     <= 1'b0;
            tx_ipv4_err      <= 1'b1;
            state            <= S_IDLE;
          end
        end
        S_DONE: begin
          tx_ipv4_data_v <= 1'b0;
          tx_ipv4_irq    <= 1'b1;
          tx_ipv4_busy   <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ipv4.sv
// Randomized self-checking bench for tx_ipv4 against a datagram model.
// Follows TX_IPV4_CHECKSUM_EN to pick the expected checksum field.
module tb_tx_ipv4;

`ifdef TX_IPV4_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        TX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        func_en = 1'b1;
  logic [31:0] ip_addr = '0;
  logic [31:0] tx_dst_ip = '0;
  logic [7:0]  tx_tos = '0;
  logic [7:0]  tx_ttl = '0;
  logic [7:0]  tx_protocol = 8'h11;
  logic [15:0] tx_id = '0;
  logic [15:0] tx_payload_len = '0;
  logic        tx_ipv4_start = 1'b0;
  logic        tx_payload_v = 1'b0;
  logic [7:0]  tx_payload_data = '0;
  logic        tx_ipv4_busy;
  logic        tx_payload_ready;
  logic        tx_ipv4_data_v;
  logic [7:0]  tx_ipv4_data;
  logic        tx_ipv4_irq;
  logic        tx_ipv4_err;

  tx_ipv4 #(.OCT(8), .UDP(8'h11)) dut (
    .TX_CLK           (TX_CLK),
    .rst              (rst),
    .func_en          (func_en),
    .ip_addr          (ip_addr),
    .tx_dst_ip        (tx_dst_ip),
    .tx_tos           (tx_tos),
    .tx_ttl           (tx_ttl),
    .tx_protocol      (tx_protocol),
    .tx_id            (tx_id),
    .tx_payload_len   (tx_payload_len),
    .tx_ipv4_start    (tx_ipv4_start),
    .tx_ipv4_busy     (tx_ipv4_busy),
    .tx_payload_v     (tx_payload_v),
    .tx_payload_data  (tx_payload_data),
    .tx_payload_ready (tx_payload_ready),
    .tx_ipv4_data_v   (tx_ipv4_data_v),
    .tx_ipv4_data     (tx_ipv4_data),
    .tx_ipv4_irq      (tx_ipv4_irq),
    .tx_ipv4_err      (tx_ipv4_err)
  );

  always #5 TX_CLK = ~TX_CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] payload [1480];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole datagram as the receiver should see it
  function automatic void build_exp(input int n_pay);
    logic [15:0] w [10];
    int s;
    w[0] = {8'h45, tx_tos};
    w[1] = 16'(20 + int'(tx_payload_len));
    w[2] = tx_id;
    w[3] = 16'h4000;
    w[4] = {tx_ttl, tx_protocol};
    w[5] = 16'h0000;
    w[6] = ip_addr[31:16];
    w[7] = ip_addr[15:0];
    w[8] = tx_dst_ip[31:16];
    w[9] = tx_dst_ip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(w[i]);
    while ((s >> 16) != 0) s = (s & 'hffff) + (s >> 16);
    w[5] = CSUM_EN ? ~s[15:0] : 16'h0000;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
    for (int i = 0; i < n_pay; i++) exp_q.push_back(payload[i]);
  endfunction

  task automatic run(input int len, input int drop,
                     input int restart_cyc, input int rst_cyc,
                     input bit fixed, input string nm);
    int  n_pay, first_dv, last_dv, irqs, errs, err_cyc;
    int  pidx, done_at, k, n, bad;
    bit  accepted, busy1, timed_out;
    if (fixed) begin
      ip_addr = 32'hc0a80001; tx_dst_ip = 32'hc0a800c7;
      tx_tos = 8'h00; tx_ttl = 8'h40; tx_protocol = 8'h11;
      tx_id = 16'h0000;
    end else begin
      ip_addr = $urandom; tx_dst_ip = $urandom;
      tx_tos = 8'($urandom); tx_ttl = 8'($urandom);
      tx_protocol = ($urandom_range(0, 1) == 1) ? 8'h11 : 8'($urandom);
      tx_id = 16'($urandom);
    end
    tx_payload_len = 16'(len);
    for (int i = 0; i < 1480; i++) payload[i] = 8'($urandom);
    accepted = (len >= 1) && (len <= 1480);
    n_pay = (drop < 0) ? len : drop;
    build_exp(n_pay);
    got_q.delete();
    first_dv = -1; last_dv = -1; irqs = 0; errs = 0; err_cyc = -1;
    busy1 = 1'b0; pidx = 0; done_at = -1; timed_out = 1'b1;
    @(negedge TX_CLK);
    tx_ipv4_start = 1'b1;
    for (k = 1; k < 2000; k++) begin
      @(negedge TX_CLK);
      tx_ipv4_start = (k == restart_cyc);
      if (k == 1) busy1 = tx_ipv4_busy;
      if (tx_ipv4_data_v) begin
        got_q.push_back(tx_ipv4_data);
        if (first_dv < 0) first_dv = k;
        last_dv = k;
      end
      if (tx_ipv4_irq) irqs++;
      if (tx_ipv4_err) begin
        errs++;
        if (err_cyc < 0) err_cyc = k;
      end
      if (k == 2) begin
        ip_addr = $urandom; tx_dst_ip = $urandom;
        tx_tos = 8'($urandom); tx_id = 16'($urandom);
        tx_payload_len = 16'($urandom);
      end
      if (rst_cyc > 0 && k == rst_cyc + 1) begin
        chk({nm, "_rst_outs"},
            {18'd0, tx_ipv4_busy, tx_payload_ready, tx_ipv4_data_v,
             tx_ipv4_irq, tx_ipv4_err, tx_ipv4_data}, 32'd0);
        rst = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (rst_cyc > 0 && k == rst_cyc) rst = 1'b1;
      if (tx_payload_ready && pidx < 1480) begin
        tx_payload_v = (pidx != drop);
        tx_payload_data = payload[pidx];
        if (tx_payload_v) pidx++;
      end else begin
        tx_payload_v = 1'b0;
      end
      if (done_at < 0 && k >= 3 && !tx_ipv4_busy && !tx_ipv4_data_v)
        done_at = k;
      if (done_at >= 0 && k >= done_at + 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    tx_ipv4_start = 1'b0;
    tx_payload_v = 1'b0;
    chk({nm, "_timeout"}, 32'(timed_out), 32'd0);
    if (rst_cyc > 0) begin
      chk({nm, "_nbytes"}, got_q.size(), rst_cyc - 11);
      chk({nm, "_irq"}, irqs, 0);
      chk({nm, "_err"}, errs, 0);
    end else if (!accepted) begin
      chk({nm, "_err_cyc"}, err_cyc, 1);
      chk({nm, "_errs"}, errs, 1);
      chk({nm, "_nbytes"}, got_q.size(), 0);
      chk({nm, "_irq"}, irqs, 0);
      chk({nm, "_busy1"}, 32'(busy1), 0);
    end else begin
      chk({nm, "_busy1"}, 32'(busy1), 1);
      chk({nm, "_first_dv"}, first_dv, 12);
      chk({nm, "_nbytes"}, got_q.size(), 20 + n_pay);
      chk({nm, "_contig"}, last_dv - first_dv + 1, got_q.size());
      chk({nm, "_irq"}, irqs, (drop < 0) ? 1 : 0);
      chk({nm, "_err"}, errs, (drop < 0) ? 0 : 1);
      chk({nm, "_busy_end"}, 32'(tx_ipv4_busy), 0);
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 20) chk($sformatf("%s_hdr%0d", nm, i), got_q[i], exp_q[i]);
      else if (got_q[i] !== exp_q[i]) bad++;
    end
    if (n > 20) chk({nm, "_payload"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge TX_CLK);
    chk("reset_outs",
        {18'd0, tx_ipv4_busy, tx_payload_ready, tx_ipv4_data_v,
         tx_ipv4_irq, tx_ipv4_err, tx_ipv4_data}, 32'd0);
    rst = 1'b0;
    @(negedge TX_CLK);

    run(95, -1, 0, 0, 1'b1, "ref95");
    chk("ref95_csum", {got_q[10], got_q[11]},
        CSUM_EN ? 32'h0000b861 : 32'h0);
    run(0, -1, 0, 0, 1'b0, "len0");
    run(1481, -1, 0, 0, 1'b0, "len1481");
    run(10, 4, 0, 0, 1'b0, "underrun");
    run(40, -1, 5, 0, 1'b0, "restart");
    run(30, -1, 0, 19, 1'b1, "rst_mid");
    run(95, -1, 0, 0, 1'b1, "after_rst");
    chk("after_rst_csum", {got_q[10], got_q[11]},
        CSUM_EN ? 32'h0000b861 : 32'h0);

    func_en = 1'b0;
    tx_payload_len = 16'd5;
    tx_ipv4_start = 1'b1;
    repeat (2) @(negedge TX_CLK);
    tx_ipv4_start = 1'b0;
    func_en = 1'b1;
    repeat (2) @(negedge TX_CLK);
    chk("func_en_busy", 32'(tx_ipv4_busy), 0);
    chk("func_en_err", 32'(tx_ipv4_err), 0);

    run(1, -1, 0, 0, 1'b0, "len1");
    run(1480, -1, 0, 0, 1'b0, "len1480");
    for (int t = 0; t < 8; t++) begin
      int len, drop;
      len = $urandom_range(1, 64);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run(len, drop, 0, 0, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
